// File: rtl/cs_stream_framer.sv
// cs_stream_framer: buffers 32-bit input words and emits fixed-length custom stream frames with an idle gap.
// Optional define CS_FRAMER_TIMEOUT_EN flushes a partial buffer as a zero-padded frame after TIMEOUT idle cycles.
module cs_stream_framer #(
  parameter int          FRAME_LEN  = 16,
  parameter int          FIFO_DEPTH = 32,
  parameter int          GAP_CYCLES = 2,
  parameter logic [31:0] ADDR_BASE  = 32'h0000_0000,
  parameter int          TIMEOUT    = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] s_data,
  input  logic        s_valid,
  output logic        s_ready,
  output logic [31:0] cs_addr,
  output logic [31:0] cs_data,
  output logic        cs_fs,
  output logic        cs_user,
  output logic [15:0] frame_count
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam int BW = $clog2(FRAME_LEN);
  localparam int LW = $clog2(FRAME_LEN + 1);
  localparam logic [CW-1:0] DEPTH_C   = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0] FRAME_C   = CW'(FRAME_LEN);
  localparam logic [BW-1:0] LAST_BEAT = BW'(FRAME_LEN - 1);
  localparam logic [7:0]    GAP_LAST  = (GAP_CYCLES > 0) ? 8'(GAP_CYCLES - 1) : 8'd0;

  if (FRAME_LEN < 2 || FRAME_LEN > 4096 || FIFO_DEPTH < FRAME_LEN ||
      (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || GAP_CYCLES < 0 || GAP_CYCLES > 255 ||
      TIMEOUT < 1 || TIMEOUT > 65535) begin : g_bad_params
    $error("cs_stream_framer: parameter out of range");
  end

  typedef enum logic [1:0] {ST_IDLE, ST_BURST, ST_GAP} state_t;

  // Handshake: a word moves when s_valid && s_ready at the rising edge; s_ready depends only on registered state.
  state_t          state, state_nxt;
  logic [31:0]     mem [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [CW-1:0]   count;
  logic            rst_hold;
  logic            push, pop;
  logic [BW-1:0]   beat, beat_nxt;
  logic [7:0]      gap_cnt, gap_cnt_nxt;
  logic [LW-1:0]   real_left, real_left_nxt, take;
  logic [31:0]     addr_nxt, data_nxt;
  logic            fs_nxt, user_nxt, frame_done;
  logic            start_pad;

  assign s_ready = ~rst_hold & (count < DEPTH_C);
  assign push    = s_valid & s_ready;

`ifdef CS_FRAMER_TIMEOUT_EN
  localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT - 1);
  logic [15:0] timer;
  logic        partial;

  assign partial   = (state == ST_IDLE) && (count != '0) && (count < FRAME_C);
  assign start_pad = partial && (timer == TIMEOUT_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) timer <= '0;
    else if (push || !partial) timer <= '0;
    else timer <= timer + 16'd1;
  end
`else
  assign start_pad = 1'b0;
`endif

  // A padded frame pops only the words present at its start; the remaining beats carry zero data.
  assign take = start_pad ? LW'(count) : LW'(FRAME_LEN);

  always_comb begin
    state_nxt     = state;
    beat_nxt      = beat;
    gap_cnt_nxt   = gap_cnt;
    real_left_nxt = real_left;
    pop           = 1'b0;
    addr_nxt      = '0;
    data_nxt      = '0;
    fs_nxt        = 1'b0;
    user_nxt      = 1'b0;
    frame_done    = 1'b0;
    case (state)
      ST_IDLE: begin
        gap_cnt_nxt = '0;
        if (count >= FRAME_C || start_pad) begin
          pop           = 1'b1;
          data_nxt      = mem[rd_ptr];
          real_left_nxt = take - LW'(1);
          addr_nxt      = ADDR_BASE;
          fs_nxt        = 1'b1;
          user_nxt      = 1'b1;
          beat_nxt      = BW'(1);
          state_nxt     = ST_BURST;
        end
      end
      ST_BURST: begin
        user_nxt = 1'b1;
        addr_nxt = ADDR_BASE + 32'(beat);
        if (real_left != '0) begin
          pop           = 1'b1;
          data_nxt      = mem[rd_ptr];
          real_left_nxt = real_left - LW'(1);
        end
        if (beat == LAST_BEAT) begin
          frame_done = 1'b1;
          beat_nxt   = '0;
          state_nxt  = (GAP_CYCLES > 0) ? ST_GAP : ST_IDLE;
        end else begin
          beat_nxt = beat + BW'(1);
        end
      end
      ST_GAP: begin
        if (gap_cnt == GAP_LAST) begin
          gap_cnt_nxt = '0;
          state_nxt   = ST_IDLE;
        end else begin
          gap_cnt_nxt = gap_cnt + 8'd1;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rst_hold    <= 1'b1;
      state       <= ST_IDLE;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      beat        <= '0;
      gap_cnt     <= '0;
      real_left   <= '0;
      cs_addr     <= '0;
      cs_data     <= '0;
      cs_fs       <= 1'b0;
      cs_user     <= 1'b0;
      frame_count <= '0;
    end else begin
      rst_hold    <= 1'b0;
      state       <= state_nxt;
      beat        <= beat_nxt;
      gap_cnt     <= gap_cnt_nxt;
      real_left   <= real_left_nxt;
      cs_addr     <= addr_nxt;
      cs_data     <= data_nxt;
      cs_fs       <= fs_nxt;
      cs_user     <= user_nxt;
      count       <= count + CW'(push) - CW'(pop);
      frame_count <= frame_count + 16'(frame_done);
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop) rd_ptr <= rd_ptr + AW'(1);
    end
  end

  // Storage needs no reset; the pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= s_data;
  end

endmodule

// File: tb/tb_cs_stream_framer.sv
// Directed bench for cs_stream_framer: three instances (gap 2, gap 0, gap 200) sharing one clock and reset.
// Timeout scenario runs only when CS_FRAMER_TIMEOUT_EN is defined.
module tb_cs_stream_framer;
  localparam int FL    = 16;
  localparam int GAP_C = 200;

  typedef struct {
    int          cyc;
    logic [31:0] addr;
    logic [31:0] data;
    logic        fs;
  } beat_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;
  int   idle_bad = 0;

  logic [31:0] s_data_a = '0, s_data_b = '0, s_data_c = '0;
  logic        s_valid_a = 1'b0, s_valid_b = 1'b0, s_valid_c = 1'b0;
  logic        s_ready_a, s_ready_b, s_ready_c;
  logic [31:0] cs_addr_a, cs_addr_b, cs_addr_c;
  logic [31:0] cs_data_a, cs_data_b, cs_data_c;
  logic        cs_fs_a, cs_fs_b, cs_fs_c;
  logic        cs_user_a, cs_user_b, cs_user_c;
  logic [15:0] frame_count_a, frame_count_b, frame_count_c;

  beat_t       log_a[$], log_b[$], log_c[$];
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  cs_stream_framer #(.GAP_CYCLES(2)) dut_a (
    .clk(clk), .rst(rst), .s_data(s_data_a), .s_valid(s_valid_a), .s_ready(s_ready_a),
    .cs_addr(cs_addr_a), .cs_data(cs_data_a), .cs_fs(cs_fs_a), .cs_user(cs_user_a),
    .frame_count(frame_count_a));

  cs_stream_framer #(.GAP_CYCLES(0)) dut_b (
    .clk(clk), .rst(rst), .s_data(s_data_b), .s_valid(s_valid_b), .s_ready(s_ready_b),
    .cs_addr(cs_addr_b), .cs_data(cs_data_b), .cs_fs(cs_fs_b), .cs_user(cs_user_b),
    .frame_count(frame_count_b));

  cs_stream_framer #(.GAP_CYCLES(GAP_C)) dut_c (
    .clk(clk), .rst(rst), .s_data(s_data_c), .s_valid(s_valid_c), .s_ready(s_ready_c),
    .cs_addr(cs_addr_c), .cs_data(cs_data_c), .cs_fs(cs_fs_c), .cs_user(cs_user_c),
    .frame_count(frame_count_c));

  // Beat logger: every user=1 beat is recorded; any nonzero output outside a beat is counted.
  always @(negedge clk) begin
    if (cs_user_a) log_a.push_back('{cyc, cs_addr_a, cs_data_a, cs_fs_a});
    else if (cs_fs_a || cs_addr_a != 0 || cs_data_a != 0) idle_bad++;
    if (cs_user_b) log_b.push_back('{cyc, cs_addr_b, cs_data_b, cs_fs_b});
    else if (cs_fs_b || cs_addr_b != 0 || cs_data_b != 0) idle_bad++;
    if (cs_user_c) log_c.push_back('{cyc, cs_addr_c, cs_data_c, cs_fs_c});
    else if (cs_fs_c || cs_addr_c != 0 || cs_data_c != 0) idle_bad++;
  end

  function automatic logic ready_of(input int inst);
    case (inst)
      0: return s_ready_a;
      1: return s_ready_b;
      default: return s_ready_c;
    endcase
  endfunction

  function automatic int log_size(input int inst);
    case (inst)
      0: return log_a.size();
      1: return log_b.size();
      default: return log_c.size();
    endcase
  endfunction

  task automatic drive(input int inst, input logic [31:0] d, input logic v);
    case (inst)
      0: begin s_data_a = d; s_valid_a = v; end
      1: begin s_data_b = d; s_valid_b = v; end
      default: begin s_data_c = d; s_valid_c = v; end
    endcase
  endtask

  // Offers one word and returns the cycle index of the accepting edge.
  task automatic push_word(input int inst, input logic [31:0] d, output int acc_cyc, output bit stalled);
    int w;
    w = 0;
    stalled = 1'b0;
    @(negedge clk);
    drive(inst, d, 1'b1);
    while (!ready_of(inst) && w < 1000) begin
      stalled = 1'b1;
      @(negedge clk);
      w++;
    end
    checks++;
    if (w >= 1000) begin
      errors++;
      $display("FAIL push_timeout: inst %0d s_ready stayed 0 for %0d cycles, required 1", inst, w);
    end
    @(posedge clk);
    #1;
    acc_cyc = cyc;
    drive(inst, 32'h0, 1'b0);
  endtask

  task automatic wait_log(input int inst, input int n, input int maxc, input string name);
    int w;
    w = 0;
    while (log_size(inst) < n && w < maxc) begin
      @(negedge clk);
      w++;
    end
    #1;
    checks++;
    if (log_size(inst) < n) begin
      errors++;
      $display("FAIL %s: got %0d beats, required %0d", name, log_size(inst), n);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (cs_addr_a !== 32'h0 || cs_data_a !== 32'h0 || cs_fs_a !== 1'b0 || cs_user_a !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: got addr=%h data=%h fs=%b user=%b, required all 0",
               cs_addr_a, cs_data_a, cs_fs_a, cs_user_a);
    end
    checks++;
    if (frame_count_a !== 16'd0) begin
      errors++;
      $display("FAIL reset_frame_count: got %0d, required 0", frame_count_a);
    end
    checks++;
    if ({s_ready_a, s_ready_b, s_ready_c} !== 3'b000) begin
      errors++;
      $display("FAIL reset_ready_low: got %b, required 000", {s_ready_a, s_ready_b, s_ready_c});
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({s_ready_a, s_ready_b, s_ready_c} !== 3'b111) begin
      errors++;
      $display("FAIL ready_after_release: got %b, required 111", {s_ready_a, s_ready_b, s_ready_c});
    end
  endtask

  // 15 words must never start a frame; the 16th completes it with one-cycle latency.
  task automatic test_single_frame;
    int e;
    bit st;
    log_a.delete();
    for (int i = 0; i < FL - 1; i++) push_word(0, 32'h100 + i, e, st);
    repeat (50) @(negedge clk);
    #1;
    checks++;
    if (log_a.size() != 0) begin
      errors++;
      $display("FAIL no_partial_frame: got %0d beats, required 0", log_a.size());
    end
    push_word(0, 32'h10F, e, st);
    wait_log(0, FL, 100, "single_frame_beats");
    checks++;
    if (log_a.size() > 0 && log_a[0].cyc != e + 1) begin
      errors++;
      $display("FAIL first_beat_latency: got cycle %0d, required %0d", log_a[0].cyc, e + 1);
    end
    for (int k = 0; k < FL && k < log_a.size(); k++) begin
      checks++;
      if (log_a[k].data !== 32'h100 + k || log_a[k].addr !== 32'(k) ||
          log_a[k].fs !== (k == 0) || log_a[k].cyc != e + 1 + k) begin
        errors++;
        $display("FAIL single_beat%0d: got data=%h addr=%h fs=%b cyc=%0d, required data=%h addr=%h fs=%b cyc=%0d",
                 k, log_a[k].data, log_a[k].addr, log_a[k].fs, log_a[k].cyc,
                 32'h100 + k, k, (k == 0), e + 1 + k);
      end
    end
    repeat (5) @(negedge clk);
    #1;
    checks++;
    if (frame_count_a !== 16'd1 || log_a.size() != FL) begin
      errors++;
      $display("FAIL single_frame_count: got count=%0d beats=%0d, required count=1 beats=%0d",
               frame_count_a, log_a.size(), FL);
    end
  endtask

  task automatic test_back_to_back;
    int e, e15;
    bit st;
    beat_t b;
    logic [31:0] exp;
    log_b.delete();
    exp_q.delete();
    e15 = 0;
    for (int i = 0; i < 3 * FL; i++) begin
      push_word(1, 32'h200 + i, e, st);
      exp_q.push_back(32'h200 + i);
      if (i == FL - 1) e15 = e;
    end
    wait_log(1, 3 * FL, 200, "b2b_beats");
    for (int k = 0; k < 3 * FL && k < log_b.size(); k++) begin
      b = log_b[k];
      exp = exp_q.pop_front();
      checks++;
      if (b.data !== exp || b.addr !== 32'(k % FL) || b.fs !== ((k % FL) == 0) || b.cyc != e15 + 1 + k) begin
        errors++;
        $display("FAIL b2b_beat%0d: got data=%h addr=%h fs=%b cyc=%0d, required data=%h addr=%h fs=%b cyc=%0d",
                 k, b.data, b.addr, b.fs, b.cyc, exp, k % FL, ((k % FL) == 0), e15 + 1 + k);
      end
    end
    repeat (5) @(negedge clk);
    #1;
    checks++;
    if (frame_count_b !== 16'd3) begin
      errors++;
      $display("FAIL b2b_frame_count: got %0d, required 3", frame_count_b);
    end
  endtask

  // Long gap: FIFO fills to depth during the gap, so word 48 is the first to stall.
  task automatic test_backpressure;
    int e, first_stall;
    bit st;
    beat_t b;
    logic [31:0] exp;
    log_c.delete();
    exp_q.delete();
    first_stall = -1;
    for (int i = 0; i < 50; i++) begin
      push_word(2, 32'h300 + i, e, st);
      exp_q.push_back(32'h300 + i);
      if (st && first_stall < 0) first_stall = i;
    end
    checks++;
    if (first_stall != 48) begin
      errors++;
      $display("FAIL full_stall_index: got %0d, required 48", first_stall);
    end
    wait_log(2, 3 * FL, 1000, "bp_beats");
    for (int k = 0; k < 3 * FL && k < log_c.size(); k++) begin
      b = log_c[k];
      exp = exp_q.pop_front();
      checks++;
      if (b.data !== exp || b.addr !== 32'(k % FL) || b.fs !== ((k % FL) == 0)) begin
        errors++;
        $display("FAIL bp_beat%0d: got data=%h addr=%h fs=%b, required data=%h addr=%h fs=%b",
                 k, b.data, b.addr, b.fs, exp, k % FL, ((k % FL) == 0));
      end
    end
    checks++;
    if (log_c.size() > FL && log_c[FL].cyc - log_c[FL - 1].cyc != GAP_C + 1) begin
      errors++;
      $display("FAIL gap_length: got %0d cycles between beats, required %0d",
               log_c[FL].cyc - log_c[FL - 1].cyc, GAP_C + 1);
    end
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if (frame_count_c !== 16'd3) begin
      errors++;
      $display("FAIL bp_frame_count: got %0d, required 3", frame_count_c);
    end
  endtask

`ifdef CS_FRAMER_TIMEOUT_EN
  task automatic test_timeout;
    int e;
    bit st;
    logic [31:0] exp;
    log_a.delete();
    for (int i = 0; i < 5; i++) push_word(0, 32'h400 + i, e, st);
    wait_log(0, FL, 200, "timeout_beats");
    checks++;
    if (log_a.size() > 0 && log_a[0].cyc != e + 64) begin
      errors++;
      $display("FAIL timeout_start: got cycle %0d, required %0d", log_a[0].cyc, e + 64);
    end
    for (int k = 0; k < FL && k < log_a.size(); k++) begin
      exp = (k < 5) ? 32'h400 + k : 32'h0;
      checks++;
      if (log_a[k].data !== exp || log_a[k].addr !== 32'(k) || log_a[k].fs !== (k == 0)) begin
        errors++;
        $display("FAIL timeout_beat%0d: got data=%h addr=%h fs=%b, required data=%h addr=%h fs=%b",
                 k, log_a[k].data, log_a[k].addr, log_a[k].fs, exp, k, (k == 0));
      end
    end
    repeat (5) @(negedge clk);
    #1;
    checks++;
    if (frame_count_a !== 16'd2) begin
      errors++;
      $display("FAIL timeout_frame_count: got %0d, required 2", frame_count_a);
    end
  endtask
`endif

  task automatic test_reset_mid_frame;
    int e, n_before;
    bit st;
    log_a.delete();
    for (int i = 0; i < FL; i++) push_word(0, 32'h500 + i, e, st);
    repeat (4) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checks++;
    if (cs_addr_a !== 32'h0 || cs_data_a !== 32'h0 || cs_fs_a !== 1'b0 || cs_user_a !== 1'b0) begin
      errors++;
      $display("FAIL midreset_outputs: got addr=%h data=%h fs=%b user=%b, required all 0",
               cs_addr_a, cs_data_a, cs_fs_a, cs_user_a);
    end
    checks++;
    if (frame_count_a !== 16'd0 || s_ready_a !== 1'b0) begin
      errors++;
      $display("FAIL midreset_state: got frame_count=%0d ready=%b, required 0 and 0", frame_count_a, s_ready_a);
    end
    n_before = log_a.size();
    checks++;
    if (n_before != 3) begin
      errors++;
      $display("FAIL midreset_partial_beats: got %0d, required 3", n_before);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (s_ready_a !== 1'b1) begin
      errors++;
      $display("FAIL midreset_ready: got %b, required 1", s_ready_a);
    end
    repeat (100) @(negedge clk);
    #1;
    checks++;
    if (log_a.size() != n_before || frame_count_a !== 16'd0) begin
      errors++;
      $display("FAIL midreset_discard: got beats=%0d frame_count=%0d, required beats=%0d frame_count=0",
               log_a.size(), frame_count_a, n_before);
    end
  endtask

  task automatic test_idle_zero;
    checks++;
    if (idle_bad != 0) begin
      errors++;
      $display("FAIL idle_outputs_zero: got %0d nonzero idle samples, required 0", idle_bad);
    end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_backpressure();
`ifdef CS_FRAMER_TIMEOUT_EN
    test_timeout();
`endif
    test_reset_mid_frame();
    test_idle_zero();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
